ctrl_pipe_stage: RTL and testbench

- Receiver side of the ID-stage control bundle. It takes the decoded control fields and register indices of the instruction in ID.
- Carries them through the ID/EX, EX/MEM and MEM/WB control registers.
- Resolves the destination register from reg_dst in ID.
- Detects load-use and branch-operand hazards and asserts stall, inserting a bubble into EX.
- Sits between the decoder and the datapath pipeline registers; stall drives the PC and IF/ID write-enables low.

---
 rtl/ctrl_pipe_pkg.sv | 58 +++++
 rtl/ctrl_pipe_stage_hazard_detect.sv | 34 +++
 rtl/ctrl_pipe_stage.sv | 162 ++++++++++++++++
 tb/tb_ctrl_pipe_stage.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pipe_pkg.sv
// Shared constants and per-stage control bundles for the ID->EX->MEM->WB control pipe.
// Destination indices are carried beside these bundles because their width is a module parameter.
package ctrl_pipe_pkg;

    localparam logic [1:0] REG_DST_RT  = 2'b00;
    localparam logic [1:0] REG_DST_RD  = 2'b01;
    localparam logic [1:0] REG_DST_RA  = 2'b10;
    localparam logic [1:0] REG_DST_RT2 = 2'b11;

    localparam logic [1:0] MEMTOREG_ALU = 2'b00;
    localparam logic [1:0] MEMTOREG_MEM = 2'b01;
    localparam logic [1:0] MEMTOREG_PC4 = 2'b10;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_to_reg;
        logic [2:0] operation;
    } ex_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_to_reg;
    } mem_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] mem_to_reg;
    } wb_ctrl_t;

    // Later stages only keep the fields they still act on.
    function automatic mem_ctrl_t ex_to_mem(input ex_ctrl_t c);
        mem_ctrl_t m;
        m.reg_write  = c.reg_write;
        m.mem_read   = c.mem_read;
        m.mem_write  = c.mem_write;
        m.mem_to_reg = c.mem_to_reg;
        return m;
    endfunction

    function automatic wb_ctrl_t mem_to_wb(input mem_ctrl_t c);
        wb_ctrl_t w;
        w.reg_write  = c.reg_write;
        w.mem_to_reg = c.mem_to_reg;
        return w;
    endfunction

endpackage

// File: rtl/ctrl_pipe_stage_hazard_detect.sv
// Combinational load-use and branch-operand hazard detector (module ctrl_hazard_detect).
// Register 0 never creates a dependence; id_flush suppresses the stall.
module ctrl_hazard_detect #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_is_branch,
    input  logic              id_flush,
    input  logic              ex_mem_read,
    input  logic              ex_reg_write,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic              mem_mem_read,
    input  logic [REG_AW-1:0] mem_dest,
    output logic              stall
);

    logic ex_match;
    logic mem_match;
    logic load_use;
    logic br_ex;
    logic br_mem;

    // Both source fields are compared even for formats that only read rs.
    assign ex_match  = (ex_dest != '0)  && ((ex_dest == id_rs)  || (ex_dest == id_rt));
    assign mem_match = (mem_dest != '0) && ((mem_dest == id_rs) || (mem_dest == id_rt));

    assign load_use = ex_mem_read && ex_match;
    assign br_ex    = id_is_branch && ex_reg_write && ex_match;
    assign br_mem   = id_is_branch && mem_mem_read && mem_match;

    assign stall = (load_use || br_ex || br_mem) && !id_flush;

endmodule

// File: rtl/ctrl_pipe_stage.sv
// ID-stage control receiver: resolves dest, detects hazards and carries controls through EX/MEM/WB.
// Optional build macro CTRL_PIPE_PERF_EN adds stall_cnt / bubble_cnt performance counters.
module ctrl_pipe_stage
    import ctrl_pipe_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int RA_IDX = 31,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        id_reg_dst,
    input  logic [1:0]        id_mem_to_reg,
    input  logic              id_reg_write,
    input  logic              id_alu_src,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic [2:0]        id_operation,
    input  logic              id_is_branch,
    input  logic              id_flush,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    output logic              stall,
    output logic              ex_alu_src,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_reg_write,
    output logic [2:0]        ex_operation,
    output logic [1:0]        ex_mem_to_reg,
    output logic [REG_AW-1:0] ex_dest,
    output logic              mem_mem_read,
    output logic              mem_mem_write,
    output logic              mem_reg_write,
    output logic [1:0]        mem_mem_to_reg,
    output logic [REG_AW-1:0] mem_dest,
    output logic              wb_reg_write,
    output logic [1:0]        wb_mem_to_reg,
`ifdef CTRL_PIPE_PERF_EN
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
`endif
    output logic [REG_AW-1:0] wb_dest
);

    ex_ctrl_t          id_ctrl;
    logic [REG_AW-1:0] id_dest;
    logic              hz_stall;
    logic              bubble;

    ex_ctrl_t          ex_ctrl_q, ex_ctrl_d;
    logic [REG_AW-1:0] ex_dest_q, ex_dest_d;
    mem_ctrl_t         mem_ctrl_q;
    logic [REG_AW-1:0] mem_dest_q;
    wb_ctrl_t          wb_ctrl_q;
    logic [REG_AW-1:0] wb_dest_q;

    always_comb begin
        id_ctrl.reg_write  = id_reg_write;
        id_ctrl.alu_src    = id_alu_src;
        id_ctrl.mem_read   = id_mem_read;
        id_ctrl.mem_write  = id_mem_write;
        id_ctrl.mem_to_reg = id_mem_to_reg;
        id_ctrl.operation  = id_operation;
    end

    always_comb begin
        id_dest = id_rt;
        case (id_reg_dst)
            REG_DST_RD:  id_dest = id_rd;
            REG_DST_RA:  id_dest = REG_AW'(RA_IDX);
            REG_DST_RT2: id_dest = id_rt;
            default:     id_dest = id_rt;
        endcase
    end

    ctrl_hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard (
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_is_branch (id_is_branch),
        .id_flush     (id_flush),
        .ex_mem_read  (ex_ctrl_q.mem_read),
        .ex_reg_write (ex_ctrl_q.reg_write),
        .ex_dest      (ex_dest_q),
        .mem_mem_read (mem_ctrl_q.mem_read),
        .mem_dest     (mem_dest_q),
        .stall        (hz_stall)
    );

    // Registered state is being cleared during reset, so no stall is raised then.
    assign stall  = hz_stall && !rst;
    assign bubble = stall || id_flush;

    always_comb begin
        ex_ctrl_d = id_ctrl;
        ex_dest_d = id_dest;
        if (bubble) begin
            ex_ctrl_d = '0;
            ex_dest_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_ctrl_q  <= '0;
            ex_dest_q  <= '0;
            mem_ctrl_q <= '0;
            mem_dest_q <= '0;
            wb_ctrl_q  <= '0;
            wb_dest_q  <= '0;
        end else begin
            ex_ctrl_q  <= ex_ctrl_d;
            ex_dest_q  <= ex_dest_d;
            mem_ctrl_q <= ex_to_mem(ex_ctrl_q);
            mem_dest_q <= ex_dest_q;
            wb_ctrl_q  <= mem_to_wb(mem_ctrl_q);
            wb_dest_q  <= mem_dest_q;
        end
    end

    assign ex_alu_src     = ex_ctrl_q.alu_src;
    assign ex_mem_read    = ex_ctrl_q.mem_read;
    assign ex_mem_write   = ex_ctrl_q.mem_write;
    assign ex_reg_write   = ex_ctrl_q.reg_write;
    assign ex_operation   = ex_ctrl_q.operation;
    assign ex_mem_to_reg  = ex_ctrl_q.mem_to_reg;
    assign ex_dest        = ex_dest_q;
    assign mem_mem_read   = mem_ctrl_q.mem_read;
    assign mem_mem_write  = mem_ctrl_q.mem_write;
    assign mem_reg_write  = mem_ctrl_q.reg_write;
    assign mem_mem_to_reg = mem_ctrl_q.mem_to_reg;
    assign mem_dest       = mem_dest_q;
    assign wb_reg_write   = wb_ctrl_q.reg_write;
    assign wb_mem_to_reg  = wb_ctrl_q.mem_to_reg;
    assign wb_dest        = wb_dest_q;

`ifdef CTRL_PIPE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q + CNT_W'(stall);
        bubble_cnt_d = bubble_cnt_q + CNT_W'(bubble);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_pipe_stage.sv
// Self-checking bench for ctrl_pipe_stage: directed hazard scenarios then randomized traffic,
// compared against a queue model of what occupies EX, MEM and WB.
module tb_ctrl_pipe_stage;

    localparam int BW = 14; // {rw, as, mr, mw, m2r[1:0], op[2:0], dest[4:0]}

    logic       clk;
    logic       rst;
    logic [1:0] id_reg_dst, id_mem_to_reg;
    logic       id_reg_write, id_alu_src, id_mem_read, id_mem_write;
    logic [2:0] id_operation;
    logic       id_is_branch, id_flush;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       stall;
    logic       ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write;
    logic [2:0] ex_operation;
    logic [1:0] ex_mem_to_reg;
    logic [4:0] ex_dest;
    logic       mem_mem_read, mem_mem_write, mem_reg_write;
    logic [1:0] mem_mem_to_reg;
    logic [4:0] mem_dest;
    logic       wb_reg_write;
    logic [1:0] wb_mem_to_reg;
    logic [4:0] wb_dest;
`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] stall_cnt, bubble_cnt;
    logic [31:0] m_stall_cnt, m_bubble_cnt;
`endif

    ctrl_pipe_stage dut (
        .clk(clk), .rst(rst),
        .id_reg_dst(id_reg_dst), .id_mem_to_reg(id_mem_to_reg),
        .id_reg_write(id_reg_write), .id_alu_src(id_alu_src),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_operation(id_operation), .id_is_branch(id_is_branch), .id_flush(id_flush),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .stall(stall),
        .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_operation(ex_operation),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_dest(ex_dest),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg), .mem_dest(mem_dest),
        .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
`ifdef CTRL_PIPE_PERF_EN
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
`endif
        .wb_dest(wb_dest)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    logic last_stall;

    // scoreboard: exp_q[0] is in EX, [1] in MEM, [2] in WB
    logic [BW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q = {};
        for (int i = 0; i < 3; i++) exp_q.push_back('0);
`ifdef CTRL_PIPE_PERF_EN
        m_stall_cnt  = 0;
        m_bubble_cnt = 0;
`endif
    endtask

    function automatic logic [BW-1:0] id_bundle();
        logic [4:0] sel[4];
        sel[0] = id_rt;
        sel[1] = id_rd;
        sel[2] = 5'd31;
        sel[3] = id_rt;
        return {id_reg_write, id_alu_src, id_mem_read, id_mem_write,
                id_mem_to_reg, id_operation, sel[id_reg_dst]};
    endfunction

    function automatic bit reads(input logic [4:0] d);
        return (d != 0) && (d == id_rs || d == id_rt);
    endfunction

    function automatic logic model_stall();
        logic [BW-1:0] ex, mem;
        ex  = exp_q[0];
        mem = exp_q[1];
        if (rst || id_flush) return 1'b0;
        return (ex[11] && reads(ex[4:0]))
            || (id_is_branch && ex[13] && reads(ex[4:0]))
            || (id_is_branch && mem[11] && reads(mem[4:0]));
    endfunction

    // one clock: check stall before the edge, advance model, check stages after
    task automatic cycle();
        logic st;
        logic [BW-1:0] w;
        #1;
        st = model_stall();
        chk("stall", 32'(stall), 32'(st));
        last_stall = st;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            w = (st || id_flush) ? '0 : id_bundle();
            exp_q.push_front(w);
            void'(exp_q.pop_back());
`ifdef CTRL_PIPE_PERF_EN
            m_stall_cnt  = m_stall_cnt + 32'(st);
            m_bubble_cnt = m_bubble_cnt + 32'(st || id_flush);
`endif
        end
        @(negedge clk);
        w = exp_q[0];
        chk("ex_stage", 32'({ex_reg_write, ex_alu_src, ex_mem_read, ex_mem_write,
                             ex_mem_to_reg, ex_operation, ex_dest}), 32'(w));
        w = exp_q[1];
        chk("mem_stage", 32'({mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_dest}),
            32'({w[13], w[11], w[10], w[9:8], w[4:0]}));
        w = exp_q[2];
        chk("wb_stage", 32'({wb_reg_write, wb_mem_to_reg, wb_dest}), 32'({w[13], w[9:8], w[4:0]}));
`ifdef CTRL_PIPE_PERF_EN
        chk("stall_cnt", stall_cnt, m_stall_cnt);
        chk("bubble_cnt", bubble_cnt, m_bubble_cnt);
`endif
    endtask

    // driver tasks
    task automatic set_instr(input logic [1:0] rd_sel, input logic [1:0] m2r, input logic rw,
                             input logic as, input logic mr, input logic mw, input logic [2:0] op,
                             input logic br, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd);
        id_reg_dst = rd_sel; id_mem_to_reg = m2r; id_reg_write = rw; id_alu_src = as;
        id_mem_read = mr; id_mem_write = mw; id_operation = op; id_is_branch = br;
        id_rs = rs; id_rt = rt; id_rd = rd;
    endtask

    task automatic nop();       set_instr(2'b00, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0); endtask
    task automatic lw(input logic [4:0] rt);
        set_instr(2'b00, 2'b01, 1, 1, 1, 0, 3'b010, 0, 5'd1, rt, 5'd0);
    endtask
    task automatic add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        set_instr(2'b01, 2'b00, 1, 0, 0, 0, 3'b010, 0, rs, rt, rd);
    endtask
    task automatic beq(input logic [4:0] rs, input logic [4:0] rt);
        set_instr(2'b00, 2'b00, 0, 0, 0, 0, 3'b110, 1, rs, rt, 5'd0);
    endtask

    // hold the ID instruction while it stalls, bounded; checks stall length when exp >= 0
    task automatic issue(input string tag, input int exp_stalls);
        int n = 0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (!last_stall) break;
            n++;
        end
        if (exp_stalls >= 0) chk(tag, n, exp_stalls);
    endtask

    task automatic drain();
        nop();
        for (int k = 0; k < 3; k++) cycle();
    endtask

    initial begin
        id_flush = 0;
        rst = 1;
        set_instr(2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 3'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
        model_reset();
        cycle();
        cycle();
        chk("rst_ex_reg_write", 32'(ex_reg_write), 0);
        chk("rst_wb_dest", 32'(wb_dest), 0);
        rst = 0;
        drain();

        // propagation through all stages
        add(5'd1, 5'd2, 5'd8);
        issue("rtype_stall", 0);
        chk("prop_ex_dest", 32'(ex_dest), 8);
        nop(); cycle();
        chk("prop_mem_dest", 32'(mem_dest), 8);
        cycle();
        chk("prop_wb_rw", 32'(wb_reg_write), 1);
        chk("prop_wb_dest", 32'(wb_dest), 8);
        drain();

        // load-use: one stall cycle
        lw(5'd9);          issue("lw9", 0);
        add(5'd9, 5'd3, 5'd10); issue("load_use_len", 1);
        chk("lu_add_in_ex", 32'(ex_dest), 10);
        drain();

        // branch after load: two stall cycles; after ALU: one
        lw(5'd4);          issue("lw4", 0);
        beq(5'd4, 5'd5);   issue("br_load_len", 2);
        drain();
        add(5'd1, 5'd2, 5'd4); issue("add4", 0);
        beq(5'd4, 5'd5);   issue("br_alu_len", 1);
        drain();

        // register zero never hazards
        lw(5'd0);          issue("lw0", 0);
        add(5'd0, 5'd0, 5'd11); issue("r0_len", 0);
        drain();

        // jal writes the link register with PC+4
        set_instr(2'b10, 2'b10, 1, 0, 0, 0, 3'b000, 0, 5'd0, 5'd0, 5'd0);
        issue("jal", 0);
        chk("jal_ex_dest", 32'(ex_dest), 31);
        nop(); cycle(); cycle();
        chk("jal_wb_m2r", 32'(wb_mem_to_reg), 2);
        drain();

        // flush beats a load-use hazard
        lw(5'd7);          issue("lw7", 0);
        add(5'd7, 5'd7, 5'd12);
        id_flush = 1;
        cycle();
        chk("flush_stall", 32'(last_stall), 0);
        chk("flush_bubble", 32'(ex_reg_write), 0);
        id_flush = 0;
        drain();

        // reset in the middle of a stall
        lw(5'd6);          issue("lw6", 0);
        add(5'd6, 5'd1, 5'd13);
        cycle();
        chk("pre_rst_stall", 32'(last_stall), 1);
        rst = 1;
        cycle();
        rst = 0;
        chk("mid_rst_ex_rw", 32'(ex_reg_write), 0);
        drain();

        // randomized traffic with small register indices to provoke hazards
        for (int i = 0; i < 400; i++) begin
            set_instr(2'($urandom), 2'($urandom_range(0, 2)), 1'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            id_flush = ($urandom_range(0, 7) == 0);
            rst      = ($urandom_range(0, 49) == 0);
            cycle();
        end
        rst = 0;
        id_flush = 0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
